// File: rtl/intersection_scheduler.sv
// Two-direction intersection phase sequencer with latched left-turn and
// pedestrian requests and a flashing fault mode.
module intersection_scheduler #(
    parameter int GREEN_CYCLES   = 20,
    parameter int YELLOW_CYCLES  = 4,
    parameter int ALL_RED_CYCLES = 2,
    parameter int LEFT_CYCLES    = 6,
    parameter int PED_CYCLES     = 8,
    parameter int FLASH_CYCLES   = 5
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       in_issue,
    input  logic       in_ped_req_ns,
    input  logic       in_ped_req_ew,
    input  logic       in_left_req_ns,
    input  logic       in_left_req_ew,
    output logic       out_red_ns,
    output logic       out_green_ns,
    output logic       out_yellow_ns,
    output logic       out_left_ns,
    output logic       out_ped_ns,
    output logic       out_red_ew,
    output logic       out_green_ew,
    output logic       out_yellow_ew,
    output logic       out_left_ew,
    output logic       out_ped_ew,
    output logic [3:0] out_phase,
    output logic       out_fault
);

    typedef enum logic [3:0] {
        NS_LEFT   = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        ALL_RED_1 = 4'd3,
        EW_LEFT   = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
        ALL_RED_2 = 4'd7,
        FAULT     = 4'd8
    } phase_e;

    // The walk lamp is lit while the down-counter is still in the top
    // PED_CYCLES values of the green load; written as >= to stay valid
    // when PED_CYCLES equals GREEN_CYCLES.
    localparam logic [15:0] PED_THRESH = 16'(GREEN_CYCLES - PED_CYCLES);
    localparam logic [15:0] FLASH_LOAD = 16'(FLASH_CYCLES - 1);

    phase_e      phase_q, phase_d;
    logic [15:0] timer_q, timer_d;
    logic        flash_q, flash_d;
    logic        left_latch_ns_q, left_latch_ns_d;
    logic        left_latch_ew_q, left_latch_ew_d;
    logic        ped_latch_ns_q, ped_latch_ns_d;
    logic        ped_latch_ew_q, ped_latch_ew_d;
    logic        ped_active_ns_q, ped_active_ns_d;
    logic        ped_active_ew_q, ped_active_ew_d;

    function automatic logic [15:0] loadFor(input phase_e p);
        case (p)
            NS_LEFT, EW_LEFT:     loadFor = 16'(LEFT_CYCLES - 1);
            NS_GREEN, EW_GREEN:   loadFor = 16'(GREEN_CYCLES - 1);
            NS_YELLOW, EW_YELLOW: loadFor = 16'(YELLOW_CYCLES - 1);
            FAULT:                loadFor = FLASH_LOAD;
            default:              loadFor = 16'(ALL_RED_CYCLES - 1);
        endcase
    endfunction

    // State, timer, flash and request registers; reset parks in all-red.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            phase_q         <= ALL_RED_2;
            timer_q         <= 16'(ALL_RED_CYCLES - 1);
            flash_q         <= 1'b0;
            left_latch_ns_q <= 1'b0;
            left_latch_ew_q <= 1'b0;
            ped_latch_ns_q  <= 1'b0;
            ped_latch_ew_q  <= 1'b0;
            ped_active_ns_q <= 1'b0;
            ped_active_ew_q <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            timer_q         <= timer_d;
            flash_q         <= flash_d;
            left_latch_ns_q <= left_latch_ns_d;
            left_latch_ew_q <= left_latch_ew_d;
            ped_latch_ns_q  <= ped_latch_ns_d;
            ped_latch_ew_q  <= ped_latch_ew_d;
            ped_active_ns_q <= ped_active_ns_d;
            ped_active_ew_q <= ped_active_ew_d;
        end
    end

    // Next phase, timer reload, flash toggling and request bookkeeping.
    always_comb begin
        phase_d         = phase_q;
        timer_d         = timer_q - 16'd1;
        flash_d         = flash_q;
        left_latch_ns_d = left_latch_ns_q;
        left_latch_ew_d = left_latch_ew_q;
        ped_latch_ns_d  = ped_latch_ns_q;
        ped_latch_ew_d  = ped_latch_ew_q;
        ped_active_ns_d = ped_active_ns_q;
        ped_active_ew_d = ped_active_ew_q;

        if (phase_q == FAULT) begin
            if (!in_issue) begin
                phase_d = ALL_RED_2;
                timer_d = loadFor(ALL_RED_2);
            end else if (timer_q == 16'd0) begin
                timer_d = FLASH_LOAD;
                flash_d = ~flash_q;
            end
        end else if (in_issue) begin
            phase_d         = FAULT;
            timer_d         = FLASH_LOAD;
            flash_d         = 1'b0;
            left_latch_ns_d = 1'b0;
            left_latch_ew_d = 1'b0;
            ped_latch_ns_d  = 1'b0;
            ped_latch_ew_d  = 1'b0;
            ped_active_ns_d = 1'b0;
            ped_active_ew_d = 1'b0;
        end else begin
            left_latch_ns_d = left_latch_ns_q | in_left_req_ns;
            left_latch_ew_d = left_latch_ew_q | in_left_req_ew;
            ped_latch_ns_d  = ped_latch_ns_q | in_ped_req_ns;
            ped_latch_ew_d  = ped_latch_ew_q | in_ped_req_ew;
            if (timer_q == 16'd0) begin
                case (phase_q)
                    ALL_RED_2: phase_d = left_latch_ns_q ? NS_LEFT : NS_GREEN;
                    NS_LEFT:   phase_d = NS_GREEN;
                    NS_GREEN:  phase_d = NS_YELLOW;
                    NS_YELLOW: phase_d = ALL_RED_1;
                    ALL_RED_1: phase_d = left_latch_ew_q ? EW_LEFT : EW_GREEN;
                    EW_LEFT:   phase_d = EW_GREEN;
                    EW_GREEN:  phase_d = EW_YELLOW;
                    EW_YELLOW: phase_d = ALL_RED_2;
                    default:   phase_d = ALL_RED_2;
                endcase
                timer_d = loadFor(phase_d);
                if (phase_d == NS_LEFT) left_latch_ns_d = 1'b0;
                if (phase_d == EW_LEFT) left_latch_ew_d = 1'b0;
                if (phase_q == NS_GREEN) ped_active_ns_d = 1'b0;
                if (phase_q == EW_GREEN) ped_active_ew_d = 1'b0;
                if (phase_d == NS_GREEN && ped_latch_ns_d) begin
                    ped_active_ns_d = 1'b1;
                    ped_latch_ns_d  = 1'b0;
                end
                if (phase_d == EW_GREEN && ped_latch_ew_d) begin
                    ped_active_ew_d = 1'b1;
                    ped_latch_ew_d  = 1'b0;
                end
            end
        end
    end

    // Lamp decode: each direction is red unless the phase grants it.
    always_comb begin
        out_red_ns    = 1'b0;
        out_green_ns  = 1'b0;
        out_yellow_ns = 1'b0;
        out_left_ns   = 1'b0;
        out_ped_ns    = 1'b0;
        out_red_ew    = 1'b0;
        out_green_ew  = 1'b0;
        out_yellow_ew = 1'b0;
        out_left_ew   = 1'b0;
        out_ped_ew    = 1'b0;
        out_fault     = 1'b0;
        if (phase_q == FAULT) begin
            out_yellow_ns = flash_q;
            out_red_ew    = flash_q;
            out_fault     = 1'b1;
        end else begin
            case (phase_q)
                NS_LEFT: begin
                    out_left_ns = 1'b1;
                    out_red_ns  = 1'b1;
                end
                NS_GREEN: begin
                    out_green_ns = 1'b1;
                    out_ped_ns   = ped_active_ns_q && (timer_q >= PED_THRESH);
                end
                NS_YELLOW: out_yellow_ns = 1'b1;
                default:   out_red_ns    = 1'b1;
            endcase
            case (phase_q)
                EW_LEFT: begin
                    out_left_ew = 1'b1;
                    out_red_ew  = 1'b1;
                end
                EW_GREEN: begin
                    out_green_ew = 1'b1;
                    out_ped_ew   = ped_active_ew_q && (timer_q >= PED_THRESH);
                end
                EW_YELLOW: out_yellow_ew = 1'b1;
                default:   out_red_ew    = 1'b1;
            endcase
        end
    end

    assign out_phase = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized bench for intersection_scheduler against a cycle-counting
// behavioural model of the phase sequence, requests and fault flashing.
module tb_intersection_scheduler;

    localparam int GREEN   = 20;
    localparam int YELLOW  = 4;
    localparam int ALLRED  = 2;
    localparam int LEFT    = 6;
    localparam int PED     = 8;
    localparam int FLASH   = 5;

    logic       in_clock;
    logic       in_reset_n;
    logic       in_issue;
    logic       in_ped_req_ns, in_ped_req_ew;
    logic       in_left_req_ns, in_left_req_ew;
    logic       out_red_ns, out_green_ns, out_yellow_ns, out_left_ns, out_ped_ns;
    logic       out_red_ew, out_green_ew, out_yellow_ew, out_left_ew, out_ped_ew;
    logic [3:0] out_phase;
    logic       out_fault;

    intersection_scheduler #(
        .GREEN_CYCLES(GREEN), .YELLOW_CYCLES(YELLOW), .ALL_RED_CYCLES(ALLRED),
        .LEFT_CYCLES(LEFT), .PED_CYCLES(PED), .FLASH_CYCLES(FLASH)
    ) dut (
        .in_clock(in_clock), .in_reset_n(in_reset_n), .in_issue(in_issue),
        .in_ped_req_ns(in_ped_req_ns), .in_ped_req_ew(in_ped_req_ew),
        .in_left_req_ns(in_left_req_ns), .in_left_req_ew(in_left_req_ew),
        .out_red_ns(out_red_ns), .out_green_ns(out_green_ns),
        .out_yellow_ns(out_yellow_ns), .out_left_ns(out_left_ns),
        .out_ped_ns(out_ped_ns), .out_red_ew(out_red_ew),
        .out_green_ew(out_green_ew), .out_yellow_ew(out_yellow_ew),
        .out_left_ew(out_left_ew), .out_ped_ew(out_ped_ew),
        .out_phase(out_phase), .out_fault(out_fault)
    );

    // Free-running clock, period 10.
    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    int checks = 0;
    int failures = 0;

    // Model state: phase code, clocks already spent in it, flash counter.
    int mPhase, mElapsed, mFcnt;
    bit mFlash, mLeftNs, mLeftEw, mPedNs, mPedEw, mActNs, mActEw;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int durOf(input int p);
        case (p)
            0, 4:    return LEFT;
            1, 5:    return GREEN;
            2, 6:    return YELLOW;
            8:       return FLASH;
            default: return ALLRED;
        endcase
    endfunction

    task automatic modelReset();
        mPhase = 7; mElapsed = 0; mFcnt = 0; mFlash = 0;
        mLeftNs = 0; mLeftEw = 0; mPedNs = 0; mPedEw = 0; mActNs = 0; mActEw = 0;
    endtask

    task automatic modelStep(input bit issue, input bit pn, input bit pe, input bit ln, input bit le);
        int nxt;
        if (mPhase == 8) begin
            if (!issue) begin
                mPhase = 7; mElapsed = 0;
            end else if (mFcnt == FLASH - 1) begin
                mFlash = !mFlash; mFcnt = 0;
            end else begin
                mFcnt++;
            end
            return;
        end
        if (issue) begin
            mPhase = 8; mFcnt = 0; mFlash = 0;
            mLeftNs = 0; mLeftEw = 0; mPedNs = 0; mPedEw = 0; mActNs = 0; mActEw = 0;
            return;
        end
        nxt = mPhase;
        if (mElapsed == durOf(mPhase) - 1) begin
            case (mPhase)
                7: nxt = mLeftNs ? 0 : 1;
                3: nxt = mLeftEw ? 4 : 5;
                default: nxt = mPhase + 1;
            endcase
        end
        mLeftNs = mLeftNs | ln; mLeftEw = mLeftEw | le;
        mPedNs = mPedNs | pn;   mPedEw = mPedEw | pe;
        if (nxt != mPhase) begin
            if (mPhase == 1) mActNs = 0;
            if (mPhase == 5) mActEw = 0;
            if (nxt == 0) mLeftNs = 0;
            if (nxt == 4) mLeftEw = 0;
            if (nxt == 1 && mPedNs) begin mActNs = 1; mPedNs = 0; end
            if (nxt == 5 && mPedEw) begin mActEw = 1; mPedEw = 0; end
            mPhase = nxt; mElapsed = 0;
        end else begin
            mElapsed++;
        end
    endtask

    // Expected lamps packed as {ns r,g,y,l,p, ew r,g,y,l,p, fault}.
    function automatic logic [10:0] expectedLamps();
        logic [4:0] ns, ew;
        ns = 5'b0; ew = 5'b0;
        if (mPhase == 8) begin
            ns[2] = mFlash; ew[4] = mFlash;
            return {ns, ew, 1'b1};
        end
        case (mPhase)
            0: begin ns[1] = 1; ns[4] = 1; end
            1: begin ns[3] = 1; ns[0] = mActNs && (mElapsed < PED); end
            2: ns[2] = 1;
            default: ns[4] = 1;
        endcase
        case (mPhase)
            4: begin ew[1] = 1; ew[4] = 1; end
            5: begin ew[3] = 1; ew[0] = mActEw && (mElapsed < PED); end
            6: ew[2] = 1;
            default: ew[4] = 1;
        endcase
        return {ns, ew, 1'b0};
    endfunction

    task automatic checkAll();
        logic [10:0] obs;
        logic conflict;
        obs = {out_red_ns, out_green_ns, out_yellow_ns, out_left_ns, out_ped_ns,
               out_red_ew, out_green_ew, out_yellow_ew, out_left_ew, out_ped_ew, out_fault};
        conflict = (out_green_ns | out_yellow_ns | out_left_ns) &
                   (out_green_ew | out_yellow_ew | out_left_ew);
        checkOutput("phase", 16'(out_phase), 16'(mPhase));
        checkOutput("lamps", 16'(obs), 16'(expectedLamps()));
        checkOutput("conflict", 16'(conflict), 16'd0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic applyStimulus(input bit issue, input bit pn, input bit pe, input bit ln, input bit le);
        in_issue = issue; in_ped_req_ns = pn; in_ped_req_ew = pe;
        in_left_req_ns = ln; in_left_req_ew = le;
        @(posedge in_clock);
        modelStep(issue, pn, pe, ln, le);
        #1;
        checkAll();
    endtask

    task automatic runUntil(input int p, input int budget);
        int n;
        n = 0;
        while (mPhase != p && n < budget) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("reach_phase", 16'(mPhase), 16'(p));
    endtask

    initial begin
        int faultLeft;
        bit issue;
        int n;
        in_reset_n = 1'b0; in_issue = 0;
        in_ped_req_ns = 0; in_ped_req_ew = 0; in_left_req_ns = 0; in_left_req_ew = 0;
        modelReset();
        #12;
        checkAll();
        @(posedge in_clock); #1;
        in_reset_n = 1'b1;

        // Idle cycle through one full period, with left-turn and walk requests.
        runUntil(1, 10);
        applyStimulus(0, 0, 0, 0, 1);
        runUntil(5, 60);
        applyStimulus(0, 1, 0, 0, 0);
        runUntil(1, 60);
        repeat (4) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        runUntil(1, 80);

        // Fault request on the same edge ALL_RED_1 would expire.
        n = 0;
        while (!(mPhase == 3 && mElapsed == ALLRED - 1) && n < 200) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("allred1_last", 16'(mPhase), 16'd3);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("fault_override", 16'(out_phase), 16'd8);
        repeat (14) applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fault_exit", 16'(out_phase), 16'd7);

        // Randomized operation with an asynchronous reset mid NS_GREEN.
        faultLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                runUntil(1, 120);
                applyStimulus(0, 0, 0, 1, 1);
                in_left_req_ns = 0; in_left_req_ew = 0;
                #2;
                in_reset_n = 1'b0;
                #1;
                modelReset();
                checkAll();
                @(posedge in_clock); #1;
                checkAll();
                in_reset_n = 1'b1;
            end
            if (faultLeft == 0 && $urandom_range(0, 499) == 0)
                faultLeft = $urandom_range(1, 30);
            issue = (faultLeft > 0);
            if (faultLeft > 0) faultLeft--;
            applyStimulus(issue,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
